// File: rtl/cpu_pkg.sv
// Shared CPU definitions: WB control-field offsets, WB retire state encoding,
// common widths and the default halt-drain length.
package cpu_pkg;

    // Datapath and field widths
    localparam int unsigned XLEN        = 16;
    localparam int unsigned RD_W        = 4;
    localparam int unsigned WB_SIG_W    = 8;
    localparam int unsigned DRAIN_CNT_W = 4;

    // Bit offsets inside MEM_WB_WB_signals = {rd[3:0], RegWrite, MemtoReg, HLT, PCS}
    localparam int unsigned RD_MSB   = 7;
    localparam int unsigned RD_LSB   = 4;
    localparam int unsigned REGWRITE = 3;
    localparam int unsigned MEMTOREG = 2;
    localparam int unsigned HLT      = 1;
    localparam int unsigned PCS      = 0;

    // Cycles spent draining after a retiring HLT (legal 1..15)
    localparam int unsigned DRAIN_CYCLES_DEFAULT = 2;

    // Retire-unit state encoding
    typedef enum logic [1:0] {
        ST_RUN    = 2'b00,
        ST_DRAIN  = 2'b01,
        ST_HALTED = 2'b10
    } wb_state_e;

endpackage

// File: rtl/wb_sat_counter.sv
// Saturating up-counter used for the retire-stage performance counters.
module wb_sat_counter #(
    parameter int unsigned CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_en,
    output logic [CNT_WIDTH-1:0] o_cnt
);

    logic [CNT_WIDTH-1:0] r_cnt;

    // Count enabled cycles, sticking at all-ones instead of wrapping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_en && (r_cnt != '1)) begin
            r_cnt <= r_cnt + CNT_WIDTH'(1);
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/wb_retire_unit.sv
// Write-back / retire stage: write-back select, register-file write port,
// deferred D-cache LRU update and the halt drain sequence.
// Optional performance counters are built when WB_PERF_CNT_EN is defined;
// otherwise retired_cnt and cycle_cnt are tied to zero.
module wb_retire_unit
    import cpu_pkg::*;
#(
    parameter int unsigned DRAIN_CYCLES = DRAIN_CYCLES_DEFAULT,
    parameter int unsigned CNT_WIDTH    = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 MEM_WB_valid,
    input  logic [XLEN-1:0]      MEM_WB_PC_next,
    input  logic [XLEN-1:0]      MEM_WB_ALU_out,
    input  logic [XLEN-1:0]      MEM_WB_MemData,
    input  logic                 MEM_WB_MemEnable,
    input  logic                 MEM_WB_first_tag_LRU,
    input  logic                 MEM_WB_first_match,
    input  logic                 MEM_WB_DCACHE_hit,
    input  logic [WB_SIG_W-1:0]  MEM_WB_WB_signals,
    output logic                 rf_wen,
    output logic [RD_W-1:0]      rf_waddr,
    output logic [XLEN-1:0]      rf_wdata,
    output logic                 lru_upd_en,
    output logic                 lru_upd_first_lru,
    output logic                 hlt,
    output logic [CNT_WIDTH-1:0] retired_cnt,
    output logic [CNT_WIDTH-1:0] cycle_cnt
);

    wb_state_e              r_state;
    logic [DRAIN_CNT_W-1:0] r_drain_cnt;
    logic                   r_hlt;
    logic                   r_lru_upd_en;
    logic                   r_lru_first;

    logic [RD_W-1:0]        w_rd;
    logic                   w_regwrite;
    logic                   w_memtoreg;
    logic                   w_hlt_bit;
    logic                   w_pcs;
    logic                   w_run;
    logic                   w_accepted;
    logic                   w_lru_hit;
    logic                   w_unused_first_tag_lru;

    // Way-0 LRU at access time is not needed: the hit way alone decides the new LRU
    assign w_unused_first_tag_lru = &{1'b1, MEM_WB_first_tag_LRU};

    assign w_rd       = MEM_WB_WB_signals[RD_MSB:RD_LSB];
    assign w_regwrite = MEM_WB_WB_signals[REGWRITE];
    assign w_memtoreg = MEM_WB_WB_signals[MEMTOREG];
    assign w_hlt_bit  = MEM_WB_WB_signals[HLT];
    assign w_pcs      = MEM_WB_WB_signals[PCS];

    assign w_run      = (r_state == ST_RUN);
    assign w_accepted = MEM_WB_valid & w_run;
    assign w_lru_hit  = w_accepted & MEM_WB_MemEnable & MEM_WB_DCACHE_hit;

    // Write-back select and RF write port; PCS wins over MemtoReg, R0 never written
    assign rf_wdata = w_pcs      ? MEM_WB_PC_next :
                      w_memtoreg ? MEM_WB_MemData : MEM_WB_ALU_out;
    assign rf_waddr = w_rd;
    assign rf_wen   = w_accepted & w_regwrite & ~w_hlt_bit & (w_rd != '0);

    // One-cycle-deferred LRU update; a hit in way 0 makes way 1 least recent
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lru_upd_en <= 1'b0;
            r_lru_first  <= 1'b0;
        end else if (w_lru_hit) begin
            r_lru_upd_en <= 1'b1;
            r_lru_first  <= ~MEM_WB_first_match;
        end else begin
            r_lru_upd_en <= 1'b0;
        end
    end

    // Halt sequencing: RUN -> DRAIN for DRAIN_CYCLES cycles -> HALTED (absorbing)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_RUN;
            r_drain_cnt <= '0;
            r_hlt       <= 1'b0;
        end else begin
            unique case (r_state)
                ST_RUN: begin
                    if (w_accepted && w_hlt_bit) begin
                        r_state     <= ST_DRAIN;
                        r_drain_cnt <= DRAIN_CNT_W'(DRAIN_CYCLES - 1);
                    end
                end
                ST_DRAIN: begin
                    if (r_drain_cnt == '0) begin
                        r_state <= ST_HALTED;
                        r_hlt   <= 1'b1;
                    end else begin
                        r_drain_cnt <= r_drain_cnt - DRAIN_CNT_W'(1);
                    end
                end
                ST_HALTED: begin
                    r_hlt <= 1'b1;
                end
                default: begin
                    r_state     <= ST_RUN;
                    r_drain_cnt <= '0;
                    r_hlt       <= 1'b0;
                end
            endcase
        end
    end

    assign lru_upd_en        = r_lru_upd_en;
    assign lru_upd_first_lru = r_lru_first;
    assign hlt               = r_hlt;

`ifdef WB_PERF_CNT_EN
    // Retired-instruction and pre-halt cycle counters
    wb_sat_counter #(
        .CNT_WIDTH (CNT_WIDTH)
    ) u_retired_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .i_en  (w_accepted),
        .o_cnt (retired_cnt)
    );

    wb_sat_counter #(
        .CNT_WIDTH (CNT_WIDTH)
    ) u_cycle_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .i_en  (r_state != ST_HALTED),
        .o_cnt (cycle_cnt)
    );
`else
    assign retired_cnt = '0;
    assign cycle_cnt   = '0;
`endif

endmodule
